// File: rtl/demux_write_bank_if.sv
// Bus bundle for demux_write_bank: write request, clear control and the flattened entry bank.
// The readback port pair (rs/q) exists only when DEMUX_WRITE_BANK_READBACK_EN is defined.
interface demux_write_bank_if #(
    parameter int WIDTH = 32
);
    logic [2:0]         s;
    logic [WIDTH-1:0]   d;
    logic               valid;
    logic               ready;
    logic               clr;
    logic [8*WIDTH-1:0] o_bus;
    logic [7:0]         wr_onehot;
    logic               clr_done;
`ifdef DEMUX_WRITE_BANK_READBACK_EN
    logic [2:0]         rs;
    logic [WIDTH-1:0]   q;

    modport master (
        output s, d, valid, clr, rs,
        input  ready, o_bus, wr_onehot, clr_done, q
    );

    modport slave (
        input  s, d, valid, clr, rs,
        output ready, o_bus, wr_onehot, clr_done, q
    );
`else
    modport master (
        output s, d, valid, clr,
        input  ready, o_bus, wr_onehot, clr_done
    );

    modport slave (
        input  s, d, valid, clr,
        output ready, o_bus, wr_onehot, clr_done
    );
`endif
endinterface

// File: rtl/demux_write_bank.sv
// Registered 1-to-8 write demultiplexer with a one-entry pending stage and an 8-cycle sequential clear.
// Optional feature: define DEMUX_WRITE_BANK_READBACK_EN to add the registered readback port (rs -> q).
module demux_write_bank #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_write_bank_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       cnt_reg;
    logic [2:0]       cnt_next;

    logic             rdy_en_reg;
    logic             pend_v_reg;
    logic [2:0]       pend_s_reg;
    logic [WIDTH-1:0] pend_d_reg;
    logic             clr_done_reg;
    logic [WIDTH-1:0] entry_reg [8];

    logic             ready_int;
    logic [7:0]       onehot_int;
    logic             accept;
    logic             last_clear;

    // clr wins over valid on the same edge; ready is already low in CLEAR.
    assign accept     = bus.valid && ready_int && !bus.clr;
    assign last_clear = (state_reg == CLEAR) && (cnt_reg == 3'd7);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; the counter parks at 0 on exit so it never wraps
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clr) begin
                    state_next = CLEAR;
                    cnt_next   = 3'd0;
                end
            end
            CLEAR: begin
                if (cnt_reg == 3'd7) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready_int  = rdy_en_reg && (state_reg == IDLE);
        onehot_int = 8'h00;
        if (pend_v_reg) begin
            onehot_int = 8'b1 << pend_s_reg;
        end
    end

    // Held low through reset so ready only rises after the first clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_reg <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_reg <= 1'b0;
            pend_s_reg <= 3'd0;
            pend_d_reg <= '0;
        end else begin
            pend_v_reg <= accept;
            if (accept) begin
                pend_s_reg <= bus.s;
                pend_d_reg <= bus.d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_done_reg <= 1'b0;
        end else begin
            clr_done_reg <= last_clear;
        end
    end

    // Per-entry storage: a clear of this index overrides a commit landing on the same edge.
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg[gi] <= '0;
            end else if ((state_reg == CLEAR) && (cnt_reg == 3'(gi))) begin
                entry_reg[gi] <= '0;
            end else if (pend_v_reg && (pend_s_reg == 3'(gi))) begin
                entry_reg[gi] <= pend_d_reg;
            end
        end

        assign bus.o_bus[gi*WIDTH +: WIDTH] = entry_reg[gi];
    end

    assign bus.ready     = ready_int;
    assign bus.wr_onehot = onehot_int;
    assign bus.clr_done  = clr_done_reg;

`ifdef DEMUX_WRITE_BANK_READBACK_EN
    logic [WIDTH-1:0] q_reg;

    // Reads the pre-edge entry value; a commit on the same edge is not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= entry_reg[bus.rs];
        end
    end

    assign bus.q = q_reg;
`endif

endmodule

// File: tb/tb_demux_write_bank.sv
// Self-checking bench for demux_write_bank: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the entry bank.
module tb_demux_write_bank;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_write_bank_if #(.WIDTH(WIDTH)) bus ();

    demux_write_bank #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Behavioural model state
    logic [WIDTH-1:0] m_mem [8];
    logic             m_pv;
    logic [2:0]       m_ps;
    logic [WIDTH-1:0] m_pd;
    logic             m_clearing;
    int               m_cidx;
    logic             m_done;
    logic             m_rdy;
`ifdef DEMUX_WRITE_BANK_READBACK_EN
    logic [WIDTH-1:0] m_q;
`endif

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        m_pv       = 1'b0;
        m_ps       = 3'd0;
        m_pd       = '0;
        m_clearing = 1'b0;
        m_cidx     = 0;
        m_done     = 1'b0;
        m_rdy      = 1'b0;
`ifdef DEMUX_WRITE_BANK_READBACK_EN
        m_q        = '0;
`endif
    endtask

    function automatic logic [8*WIDTH-1:0] model_bus();
        logic [8*WIDTH-1:0] r;
        for (int k = 0; k < 8; k++) r[k*WIDTH +: WIDTH] = m_mem[k];
        return r;
    endfunction

    function automatic logic [7:0] model_onehot();
        return m_pv ? (8'b1 << m_ps) : 8'h00;
    endfunction

    function automatic logic model_ready();
        return m_rdy && !m_clearing;
    endfunction

    // Drive one cycle of inputs (called at a negedge), advance the model over the edge,
    // and return at the following negedge so outputs can be sampled away from the edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] d, input logic c);
        logic acc;
        bus.valid = v;
        bus.s     = s;
        bus.d     = d;
        bus.clr   = c;
`ifdef DEMUX_WRITE_BANK_READBACK_EN
        bus.rs    = 3'($urandom_range(0, 7));
`endif
        acc = v && model_ready() && !c;
        @(posedge clk);
`ifdef DEMUX_WRITE_BANK_READBACK_EN
        m_q = m_mem[bus.rs];
`endif
        if (m_pv) m_mem[m_ps] = m_pd;
        m_done = 1'b0;
        if (m_clearing) begin
            m_mem[m_cidx] = '0;
            if (m_cidx == 7) begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
            end else begin
                m_cidx++;
            end
        end else if (c) begin
            m_clearing = 1'b1;
            m_cidx     = 0;
        end
        m_pv = acc;
        if (acc) begin
            m_ps = s;
            m_pd = d;
        end
        m_rdy = 1'b1;
        @(negedge clk);
        cycle++;
        $display("txn %0d: valid=%0b s=%0d d=%h clr=%0b -> ready=%0b onehot=%h clr_done=%0b",
                 cycle, v, s, d, c, bus.ready, bus.wr_onehot, bus.clr_done);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.clr   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, '0, 1'b0);
    endtask

    task automatic test_reset();
        bus.valid = 1'b0;
        bus.clr   = 1'b0;
        bus.s     = 3'd0;
        bus.d     = '0;
`ifdef DEMUX_WRITE_BANK_READBACK_EN
        bus.rs    = 3'd0;
`endif
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        checks++;
        if (bus.o_bus !== '0) begin failures++; $display("FAIL reset_obus: got %h want 0", bus.o_bus); end
        checks++;
        if (bus.wr_onehot !== 8'h00) begin failures++; $display("FAIL reset_onehot: got %h want 00", bus.wr_onehot); end
        checks++;
        if (bus.clr_done !== 1'b0) begin failures++; $display("FAIL reset_clr_done: got %b want 0", bus.clr_done); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL release_ready_early: got %b want 0", bus.ready); end
        @(negedge clk);
        step(1'b0, 3'd0, '0, 1'b0);
        checks++;
        if (bus.ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b want 1", bus.ready); end
    endtask

    task automatic test_single_write();
        logic [8*WIDTH-1:0] exp;
        apply_reset();
        step(1'b1, 3'd5, 32'hDEADBEEF, 1'b0);
        checks++;
        if (bus.wr_onehot !== 8'h20) begin failures++; $display("FAIL single_onehot: got %h want 20", bus.wr_onehot); end
        checks++;
        if (bus.o_bus !== '0) begin failures++; $display("FAIL single_not_yet: got %h want 0", bus.o_bus); end
        step(1'b0, 3'd0, '0, 1'b0);
        exp = '0;
        exp[5*WIDTH +: WIDTH] = 32'hDEADBEEF;
        checks++;
        if (bus.o_bus !== exp) begin failures++; $display("FAIL single_obus: got %h want %h", bus.o_bus, exp); end
        checks++;
        if (bus.wr_onehot !== 8'h00) begin failures++; $display("FAIL single_onehot_idle: got %h want 00", bus.wr_onehot); end
    endtask

    task automatic test_back_to_back();
        logic [8*WIDTH-1:0] exp;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'(k), WIDTH'(k + 1), 1'b0);
            checks++;
            if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus.ready); end
            checks++;
            if (bus.wr_onehot !== (8'b1 << k)) begin
                failures++; $display("FAIL b2b_onehot[%0d]: got %h want %h", k, bus.wr_onehot, 8'b1 << k);
            end
        end
        step(1'b0, 3'd0, '0, 1'b0);
        for (int k = 0; k < 8; k++) exp[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        checks++;
        if (bus.o_bus !== exp) begin failures++; $display("FAIL b2b_obus: got %h want %h", bus.o_bus, exp); end
    endtask

    task automatic test_clear();
        int pulses;
        apply_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 32'hFFFFFFFF, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL clear_ready_start: got %b want 0", bus.ready); end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'd0, '0, 1'b0);
            if (bus.clr_done === 1'b1) pulses++;
            checks++;
            if (bus.o_bus[k*WIDTH +: WIDTH] !== '0) begin
                failures++; $display("FAIL clear_entry[%0d]: got %h want 0", k, bus.o_bus[k*WIDTH +: WIDTH]);
            end
            if (k < 7) begin
                checks++;
                if (bus.o_bus[(k+1)*WIDTH +: WIDTH] !== 32'hFFFFFFFF) begin
                    failures++; $display("FAIL clear_order[%0d]: got %h want ffffffff", k + 1, bus.o_bus[(k+1)*WIDTH +: WIDTH]);
                end
            end
            checks++;
            if (bus.ready !== (k == 7)) begin failures++; $display("FAIL clear_ready[%0d]: got %b want %b", k, bus.ready, k == 7); end
        end
        repeat (2) begin
            step(1'b0, 3'd0, '0, 1'b0);
            if (bus.clr_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL clear_done_pulses: got %0d want 1", pulses); end
        checks++;
        if (bus.o_bus !== model_bus()) begin failures++; $display("FAIL clear_model: got %h want %h", bus.o_bus, model_bus()); end
    endtask

    task automatic test_clr_priority();
        apply_reset();
        step(1'b1, 3'd3, WIDTH'(5), 1'b1);
        checks++;
        if (bus.wr_onehot !== 8'h00) begin failures++; $display("FAIL prio_onehot: got %h want 00", bus.wr_onehot); end
        repeat (8) step(1'b1, 3'd3, WIDTH'(5), 1'b0);
        step(1'b0, 3'd0, '0, 1'b0);
        checks++;
        if (bus.o_bus[3*WIDTH +: WIDTH] !== '0) begin
            failures++; $display("FAIL prio_entry3: got %h want 0", bus.o_bus[3*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_pending_then_clr();
        apply_reset();
        step(1'b1, 3'd0, WIDTH'(7), 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        repeat (9) step(1'b0, 3'd0, '0, 1'b0);
        checks++;
        if (bus.o_bus[0 +: WIDTH] !== '0) begin failures++; $display("FAIL pend_clr_entry0: got %h want 0", bus.o_bus[0 +: WIDTH]); end
        checks++;
        if (bus.o_bus !== model_bus()) begin failures++; $display("FAIL pend_clr_model: got %h want %h", bus.o_bus, model_bus()); end
    endtask

    task automatic test_reset_mid_clear();
        int pulses;
        apply_reset();
        step(1'b1, 3'd2, 32'h0000AAAA, 1'b0);
        step(1'b1, 3'd6, 32'h12345678, 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        repeat (4) step(1'b1, 3'd1, 32'h55, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.o_bus !== '0) begin failures++; $display("FAIL async_obus: got %h want 0", bus.o_bus); end
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL async_ready: got %b want 0", bus.ready); end
        checks++;
        if (bus.wr_onehot !== 8'h00) begin failures++; $display("FAIL async_onehot: got %h want 00", bus.wr_onehot); end
        checks++;
        if (bus.clr_done !== 1'b0) begin failures++; $display("FAIL async_clr_done: got %b want 0", bus.clr_done); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        step(1'b0, 3'd0, '0, 1'b0);
        checks++;
        if (bus.ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", bus.ready); end
        repeat (12) begin
            step(1'b0, 3'd0, '0, 1'b0);
            if (bus.clr_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL post_reset_pulses: got %0d want 0", pulses); end
        checks++;
        if (bus.o_bus !== '0) begin failures++; $display("FAIL post_reset_obus: got %h want 0", bus.o_bus); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), WIDTH'($urandom),
                 1'($urandom_range(0, 15) == 0));
            checks++;
            if (bus.o_bus !== model_bus()) begin failures++; $display("FAIL rand_obus[%0d]: got %h want %h", i, bus.o_bus, model_bus()); end
            checks++;
            if (bus.wr_onehot !== model_onehot()) begin failures++; $display("FAIL rand_onehot[%0d]: got %h want %h", i, bus.wr_onehot, model_onehot()); end
            checks++;
            if (bus.ready !== model_ready()) begin failures++; $display("FAIL rand_ready[%0d]: got %b want %b", i, bus.ready, model_ready()); end
            checks++;
            if (bus.clr_done !== m_done) begin failures++; $display("FAIL rand_clr_done[%0d]: got %b want %b", i, bus.clr_done, m_done); end
`ifdef DEMUX_WRITE_BANK_READBACK_EN
            checks++;
            if (bus.q !== m_q) begin failures++; $display("FAIL rand_q[%0d]: got %h want %h", i, bus.q, m_q); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear();
        test_clr_priority();
        test_pending_then_clr();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_write_bank.md
DEMUX_WRITE_BANK -- requirements
Module: demux_write_bank

Interface
REQ-001 Parameter WIDTH, default 32, data width of each destination entry.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port s  input  3  destination select, binary; 0 selects entry 0, 7 selects entry 7.
REQ-005 Port d  input  WIDTH  write data.
REQ-006 Port valid  input  1  write request qualifier.
REQ-007 Port ready  output  1  write request may be accepted this cycle.
REQ-008 Port clr  input  1  request a sequential clear of all eight entries.
REQ-009 Port o_bus  output  8*WIDTH  entry k at bits [k*WIDTH +: WIDTH].
REQ-010 Port wr_onehot  output  8  one-hot strobe for the entry being committed this cycle.
REQ-011 Port clr_done  output  1  single-cycle pulse when a clear sequence completes.

Function
REQ-012 The block SHALL be a registered 1-to-8 write demultiplexer: one input word is steered to one of eight WIDTH-bit entries.
REQ-013 FSM states SHALL be IDLE and CLEAR only.
REQ-014 In IDLE, ready SHALL be 1; in CLEAR, ready SHALL be 0.
REQ-015 Accept SHALL occur at an edge where valid=1 and ready=1; s and d are captured into a one-entry pending stage.
REQ-016 A write accepted at edge N SHALL be visible on o_bus after edge N+1 (latency 1 cycle).
REQ-017 wr_onehot SHALL equal the one-hot decode of the pending select while the pending stage is valid, and 8'h00 otherwise.
REQ-018 Back-to-back accepts SHALL be supported: one write per cycle, with no bubble.
REQ-019 Unselected entries SHALL hold their value on every commit.
REQ-020 clr=1 sampled in IDLE SHALL move the FSM to CLEAR, load the 3-bit clear counter with 0, and block any valid on that same edge (clr has priority over valid).
REQ-021 In CLEAR, each edge SHALL zero entry[counter] and increment the counter; exit to IDLE occurs on the edge that clears entry 7 (8 cycles total).
REQ-022 clr_done SHALL be 1 for exactly the cycle following the exit edge.
REQ-023 clr asserted while in CLEAR SHALL be ignored (no restart).
REQ-024 A pending write outstanding when CLEAR begins SHALL commit on the first CLEAR edge; if its target is entry 0, the clear SHALL win and entry 0 ends at 0.
REQ-025 Counter wrap from 7 SHALL NOT occur; the counter is only meaningful in CLEAR.

Reset
REQ-026 On rst_n=0, immediately and regardless of clk, the block SHALL set: all entries to 0, pending stage invalid, FSM to IDLE, counter to 0, wr_onehot to 0, clr_done to 0.
REQ-027 While rst_n=0, ready SHALL be 0; it SHALL become 1 after the first clk edge with rst_n=1.
REQ-028 Reset asserted mid-CLEAR or with a pending write SHALL abort both, and no partial state survives.

Configuration
REQ-029 Macro DEMUX_WRITE_BANK_READBACK_EN, when defined, SHALL add input rs [2:0] and output q [WIDTH-1:0].
REQ-030 With the macro defined, q SHALL be the registered copy of entry[rs] (1-cycle latency) and reset to 0; a same-cycle commit is not forwarded.
REQ-031 Without the macro, rs and q SHALL NOT exist, and behaviour is otherwise identical.

Verification
REQ-032 Reset, then valid=1, s=5, d=32'hDEADBEEF for 1 cycle -> wr_onehot=8'h20 in the next cycle; entry 5 = DEADBEEF after that edge; all other entries = 0.
REQ-033 Eight back-to-back writes with s=0..7 and d=k+1 -> ready stays 1; entries read 1..8; wr_onehot walks 01,02,...,80 with no gap.
REQ-034 All entries = FFFFFFFF, pulse clr -> ready=0 for 8 cycles; entries zero in order 0..7; clr_done pulses once; ready returns to 1.
REQ-035 clr=1 and valid=1 (s=3, d=5) on the same edge -> write not accepted; entry 3 ends at 0 after the clear.
REQ-036 Pending write s=0, d=7 followed immediately by clr -> entry 0 = 0 after the sequence.
REQ-037 Drop rst_n at clear cycle 4 -> all outputs 0 asynchronously; after release, ready=1 and clr_done never pulses.
